window_bundler: RTL and testbench

Temporal bundling stage that sits directly upstream of `similarity`. It accumulates a window of WINDOW encoded sample hypervectors into per-dimension bit counts. It then thresholds the counts by majority to produce the query hypervector `hv_out`, which drives `similarity.hv_test`. The control style matches `similarity`: an `en` start pulse, and a `done` level that is high whenever the block is idle.

---
 rtl/window_bundler.sv | 136 +++++++++++++
 tb/tb_window_bundler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/window_bundler.sv
// window_bundler: temporal majority bundler.
// Accumulates WINDOW sample hypervectors into per-dimension bit counts,
// then thresholds each count by strict majority to form hv_out.
// Control: en starts a window from IDLE; done is high while idle and
// hv_out is stable; ready is high while samples are being accepted.
module window_bundler #(
  parameter int DIMENSIONS = 10000,
  parameter int WINDOW     = 256
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  hv_valid,
  input  logic [DIMENSIONS-1:0] hv_in,
  output logic                  ready,
  output logic                  done,
  output logic [DIMENSIONS-1:0] hv_out
);

  // Count width holds 0..WINDOW; one extra bit is used for the 2*cnt compare.
  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(WINDOW - 1);
  localparam logic [CW:0]   WINDOW_EXT = (CW + 1)'(WINDOW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    THRESH = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   ready_next;
  logic   done_next;

  logic [CW-1:0]         n_acc_reg;
  logic [DIMENSIONS-1:0] thresh_bits;

  logic start;
  logic accept;
  logic last_accept;

  // A window starts only from IDLE; samples count only while in ACCUM.
  assign start       = (state_reg == IDLE) && en;
  assign accept      = (state_reg == ACCUM) && hv_valid;
  assign last_accept = accept && (n_acc_reg == LAST_IDX);

  // State and handshake output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= IDLE;
      ready     <= 1'b0;
      done      <= 1'b1;
    end else begin
      state_reg <= state_next;
      ready     <= ready_next;
      done      <= done_next;
    end
  end

  // Next-state and next ready/done decode.
  always_comb begin
    state_next = state_reg;
    ready_next = ready;
    done_next  = done;
    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = ACCUM;
          ready_next = 1'b1;
          done_next  = 1'b0;
        end
      end
      ACCUM: begin
        if (last_accept) begin
          state_next = THRESH;
          ready_next = 1'b0;
        end
      end
      THRESH: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b0;
        done_next  = 1'b1;
      end
    endcase
  end

  // Accepted-sample counter; cleared at window start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      n_acc_reg <= '0;
    end else if (start) begin
      n_acc_reg <= '0;
    end else if (accept) begin
      n_acc_reg <= n_acc_reg + 1'b1;
    end
  end

  // One count register and one majority comparator per dimension.
  // Counts never exceed WINDOW because accepts stop at the WINDOW-th sample.
  generate
    for (genvar gi = 0; gi < DIMENSIONS; gi++) begin : g_dim
      logic [CW-1:0] cnt_reg;
      logic [CW:0]   twice;

      // Per-dimension popcount of accepted samples.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          cnt_reg <= '0;
        end else if (start) begin
          cnt_reg <= '0;
        end else if (accept) begin
          cnt_reg <= cnt_reg + CW'(hv_in[gi]);
        end
      end

      // Strict majority: a tie (even WINDOW, exactly half set) gives 0.
      assign twice           = {cnt_reg, 1'b0};
      assign thresh_bits[gi] = (twice > WINDOW_EXT);
    end
  endgenerate

  // hv_out changes only on the THRESH->IDLE edge and holds otherwise.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hv_out <= '0;
    end else if (state_reg == THRESH) begin
      hv_out <= thresh_bits;
    end
  end

endmodule

// File: tb/tb_window_bundler.sv
// Directed bench for window_bundler with DIMENSIONS = 8, WINDOW = 4.
module tb_window_bundler;

  logic       clk;
  logic       nrst;
  logic       en;
  logic       hv_valid;
  logic [7:0] hv_in;
  logic       ready;
  logic       done;
  logic [7:0] hv_out;

  int checks;
  int passed;
  int edges;

  window_bundler #(
    .DIMENSIONS(8),
    .WINDOW    (4)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .hv_valid(hv_valid),
    .hv_in   (hv_in),
    .ready   (ready),
    .done    (done),
    .hv_out  (hv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Present one sample for one edge.
  task automatic feed(input logic [7:0] v);
    hv_valid = 1'b1;
    hv_in    = v;
    tick();
    hv_valid = 1'b0;
    hv_in    = 8'h00;
  endtask

  // Pulse en for one edge from IDLE.
  task automatic start_window();
    en    = 1'b1;
    edges = 0;
    tick();
    en    = 1'b0;
  endtask

  // Wait for done with a bounded cycle budget.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    edges    = 0;
    nrst     = 1'b1;
    en       = 1'b0;
    hv_valid = 1'b0;
    hv_in    = 8'h00;

    // Asynchronous reset before any clock edge.
    #2 nrst = 1'b0;
    #1;
    chk("reset_done",   {31'd0, done},   32'd1);
    chk("reset_ready",  {31'd0, ready},  32'd0);
    chk("reset_hv_out", {24'd0, hv_out}, 32'h00);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // Majority window: AA AA AA 55 -> AA, done 6 edges after en edge inclusive.
    start_window();
    chk("maj_start_ready", {31'd0, ready}, 32'd1);
    chk("maj_start_done",  {31'd0, done},  32'd0);
    feed(8'hAA);
    feed(8'hAA);
    feed(8'hAA);
    chk("maj_ready_before_last", {31'd0, ready}, 32'd1);
    feed(8'h55);
    chk("maj_ready_fall", {31'd0, ready}, 32'd0);
    chk("maj_done_low",   {31'd0, done},  32'd0);
    wait_done("maj_done_timeout");
    chk("maj_edges",  edges,           32'd6);
    chk("maj_hv_out", {24'd0, hv_out}, 32'hAA);

    // Tie window: F0 0F FF 00 -> every count is 2 -> 00.
    start_window();
    chk("tie_hold_prev", {24'd0, hv_out}, 32'hAA);
    feed(8'hF0);
    feed(8'h0F);
    feed(8'hFF);
    feed(8'h00);
    chk("tie_hold_thresh", {24'd0, hv_out}, 32'hAA);
    wait_done("tie_done_timeout");
    chk("tie_hv_out", {24'd0, hv_out}, 32'h00);

    // Majority of ones: FF FF FF 00 -> FF.
    start_window();
    feed(8'hFF);
    feed(8'hFF);
    feed(8'hFF);
    feed(8'h00);
    wait_done("ones_done_timeout");
    chk("ones_hv_out", {24'd0, hv_out}, 32'hFF);

    // Bubbles plus an en pulse during ACCUM: done two edges later.
    start_window();
    feed(8'hAA);
    en = 1'b1;
    tick();
    en = 1'b0;
    feed(8'hAA);
    feed(8'hAA);
    tick();
    chk("bub_ready_mid", {31'd0, ready}, 32'd1);
    feed(8'h55);
    wait_done("bub_done_timeout");
    chk("bub_edges",  edges,           32'd8);
    chk("bub_hv_out", {24'd0, hv_out}, 32'hAA);

    // hv_valid in IDLE is ignored and hv_out holds.
    hv_valid = 1'b1;
    hv_in    = 8'hFF;
    tick();
    tick();
    hv_valid = 1'b0;
    hv_in    = 8'h00;
    chk("idle_done",   {31'd0, done},   32'd1);
    chk("idle_ready",  {31'd0, ready},  32'd0);
    chk("idle_hv_out", {24'd0, hv_out}, 32'hAA);

    // Reset mid-window discards partial counts.
    start_window();
    feed(8'hFF);
    feed(8'hFF);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_done",   {31'd0, done},   32'd1);
    chk("mid_rst_ready",  {31'd0, ready},  32'd0);
    chk("mid_rst_hv_out", {24'd0, hv_out}, 32'h00);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    start_window();
    feed(8'h00);
    feed(8'h00);
    feed(8'h00);
    feed(8'h0F);
    wait_done("post_rst_done_timeout");
    chk("post_rst_hv_out", {24'd0, hv_out}, 32'h00);

    // Back-to-back windows with en held high.
    en    = 1'b1;
    edges = 0;
    tick();
    chk("b2b_w1_ready", {31'd0, ready}, 32'd1);
    feed(8'h0F);
    feed(8'h0F);
    feed(8'h0F);
    chk("b2b_w1_hold", {24'd0, hv_out}, 32'h00);
    feed(8'hF0);
    tick();
    chk("b2b_w1_done",   {31'd0, done},   32'd1);
    chk("b2b_w1_hv_out", {24'd0, hv_out}, 32'h0F);
    tick();
    en = 1'b0;
    chk("b2b_done_one_cycle", {31'd0, done},  32'd0);
    chk("b2b_w2_ready",       {31'd0, ready}, 32'd1);
    feed(8'hF0);
    feed(8'hF0);
    chk("b2b_w2_hold_a", {24'd0, hv_out}, 32'h0F);
    feed(8'hF0);
    feed(8'h0F);
    chk("b2b_w2_hold_b", {24'd0, hv_out}, 32'h0F);
    wait_done("b2b_w2_done_timeout");
    chk("b2b_w2_hv_out", {24'd0, hv_out}, 32'hF0);
    tick();
    chk("b2b_stay_idle", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
